// File: rtl/cpu_0_oci_pkg.sv
// Shared geometry, trace code encodings and slot state type for the OCI
// instruction-trace packer.
package cpu_0_oci_pkg;

  localparam logic [1:0] TC_SEQ    = 2'b00;
  localparam logic [1:0] TC_TAKEN  = 2'b01;
  localparam logic [1:0] TC_NTAKEN = 2'b10;
  localparam logic [1:0] TC_EXC    = 2'b11;

  localparam int unsigned DCT_SLOTS = 15;
  localparam int unsigned DCT_W     = 30;
  localparam int unsigned DCT_CNT_W = 4;
  localparam int unsigned DROP_W    = 8;

  typedef enum logic {
    SLOT_EMPTY  = 1'b0,
    SLOT_LOADED = 1'b1
  } slot_state_t;

endpackage

// File: rtl/cpu_0_oci_pkt_slot.sv
// One-entry valid/ready holding register between the trace accumulator and
// the trace-out path. A load while the current word is accepted chains back-to-back.
module cpu_0_oci_pkt_slot
  import cpu_0_oci_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DCT_W-1:0]     load_data,
  input  logic [DCT_CNT_W-1:0] load_count,
  input  logic                 pkt_ready,
  output logic                 slot_free,
  output logic                 pkt_valid,
  output logic [DCT_W-1:0]     pkt_data,
  output logic [DCT_CNT_W-1:0] pkt_count
);

  slot_state_t state;

  assign pkt_valid = (state == SLOT_LOADED);
  assign slot_free = !pkt_valid || pkt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SLOT_EMPTY;
      pkt_data  <= '0;
      pkt_count <= '0;
    end else if (load) begin
      state     <= SLOT_LOADED;
      pkt_data  <= load_data;
      pkt_count <= load_count;
    end else if (pkt_valid && pkt_ready) begin
      state <= SLOT_EMPTY;
    end
  end

endmodule

// File: rtl/cpu_0_nios2_oci_dct_packer.sv
// Packs 2-bit trace codes into 30-bit words of up to 15 codes; never stalls
// the CPU, so codes that find no room are dropped and counted.
module cpu_0_nios2_oci_dct_packer
  import cpu_0_oci_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_en,
  input  logic        trace_valid,
  input  logic [1:0]  trace_code,
  input  logic        flush,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        pkt_valid,
  output logic [29:0] pkt_data,
  output logic [3:0]  pkt_count,
  input  logic        pkt_ready,
  output logic        ovf,
  output logic [7:0]  drop_count
);

  logic                 acc;
  logic                 full;
  logic                 flush_req;
  logic                 flush_pend;
  logic                 slot_free;
  logic                 load;
  logic                 drop;
  logic [DCT_W-1:0]     post_buf;
  logic [DCT_CNT_W-1:0] post_cnt;
  logic [DCT_W-1:0]     buf_nxt;
  logic [DCT_CNT_W-1:0] cnt_nxt;

  always_comb begin
    acc       = trace_en && trace_valid;
    full      = (dct_count == DCT_CNT_W'(DCT_SLOTS));
    flush_req = flush || flush_pend;
    post_buf  = dct_buffer;
    post_cnt  = dct_count;
    load      = 1'b0;
    drop      = 1'b0;
    buf_nxt   = dct_buffer;
    cnt_nxt   = dct_count;

    if (acc && !full) begin
      post_buf = {dct_buffer[DCT_W-3:0], trace_code};
      post_cnt = dct_count + 4'd1;
    end

    // A full accumulator hands off its 15 old codes; the arriving code then
    // starts the next word rather than being appended.
    if (acc && full) begin
      if (slot_free) begin
        load    = 1'b1;
        buf_nxt = {{(DCT_W-2){1'b0}}, trace_code};
        cnt_nxt = 4'd1;
      end else begin
        drop = 1'b1;
      end
    end else begin
      load = slot_free &&
             ((post_cnt == DCT_CNT_W'(DCT_SLOTS)) || (flush_req && post_cnt != '0));
      buf_nxt = load ? '0 : post_buf;
      cnt_nxt = load ? '0 : post_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      flush_pend <= 1'b0;
      ovf        <= 1'b0;
      drop_count <= '0;
    end else begin
      dct_buffer <= buf_nxt;
      dct_count  <= cnt_nxt;
      flush_pend <= flush_req && !slot_free;
      if (drop) begin
        ovf <= 1'b1;
        if (drop_count != '1)
          drop_count <= drop_count + 8'd1;
      end
    end
  end

  cpu_0_oci_pkt_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (post_buf),
    .load_count (post_cnt),
    .pkt_ready  (pkt_ready),
    .slot_free  (slot_free),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_count  (pkt_count)
  );

endmodule

// File: tb/tb_cpu_0_nios2_oci_dct_packer.sv
// Directed self-checking bench for the OCI trace packer.
module tb_cpu_0_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en;
  logic        trace_valid;
  logic [1:0]  trace_code;
  logic        flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        pkt_valid;
  logic [29:0] pkt_data;
  logic [3:0]  pkt_count;
  logic        pkt_ready;
  logic        ovf;
  logic [7:0]  drop_count;

  int tests = 0;
  int fails = 0;

  cpu_0_nios2_oci_dct_packer dut (
    .clk         (clk),
    .reset       (reset),
    .trace_en    (trace_en),
    .trace_valid (trace_valid),
    .trace_code  (trace_code),
    .flush       (flush),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .pkt_count   (pkt_count),
    .pkt_ready   (pkt_ready),
    .ovf         (ovf),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Inputs are applied between edges; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] code, input int n);
    trace_valid = 1'b1;
    trace_code  = code;
    for (int i = 0; i < n; i++) step();
    trace_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; trace_en = 1'b1; trace_valid = 1'b0; trace_code = 2'b00;
    flush = 1'b0; pkt_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    tests++;
    if ({dct_buffer, dct_count, pkt_valid, pkt_data, pkt_count, ovf, drop_count} !== '0) begin
      $display("FAIL reset_state: got buf=%h cnt=%0d pv=%b pd=%h pc=%0d ovf=%b drops=%0d, want all 0",
               dct_buffer, dct_count, pkt_valid, pkt_data, pkt_count, ovf, drop_count);
      fails++;
    end
  endtask

  task automatic test_trace_en();
    trace_en = 1'b0;
    send(2'b11, 3);
    trace_en = 1'b1;
    tests++;
    if (dct_count !== 4'd0 || drop_count !== 8'd0) begin
      $display("FAIL trace_en_low: got cnt=%0d drops=%0d, want cnt=0 drops=0", dct_count, drop_count);
      fails++;
    end
  endtask

  task automatic test_full_word();
    pkt_ready = 1'b1;
    send(2'b01, 14);
    tests++;
    if (dct_count !== 4'd14 || pkt_valid !== 1'b0) begin
      $display("FAIL full_partial: got cnt=%0d pv=%b, want cnt=14 pv=0", dct_count, pkt_valid);
      fails++;
    end
    send(2'b01, 1);
    tests++;
    if (pkt_valid !== 1'b1 || pkt_data !== 30'h15555555 || pkt_count !== 4'd15 || dct_count !== 4'd0) begin
      $display("FAIL full_word: got pv=%b pd=%h pc=%0d cnt=%0d, want pv=1 pd=15555555 pc=15 cnt=0",
               pkt_valid, pkt_data, pkt_count, dct_count);
      fails++;
    end
    step();
    tests++;
    if (pkt_valid !== 1'b0) begin
      $display("FAIL full_accept: got pv=%b, want 0", pkt_valid);
      fails++;
    end
  endtask

  task automatic test_flush();
    send(2'b01, 1); send(2'b10, 1); send(2'b11, 1);
    tests++;
    if (dct_buffer !== 30'h1B || dct_count !== 4'd3) begin
      $display("FAIL flush_acc: got buf=%h cnt=%0d, want buf=1b cnt=3", dct_buffer, dct_count);
      fails++;
    end
    flush = 1'b1; step(); flush = 1'b0;
    tests++;
    if (pkt_valid !== 1'b1 || pkt_data !== 30'h1B || pkt_count !== 4'd3 ||
        dct_count !== 4'd0 || dct_buffer !== 30'h0) begin
      $display("FAIL flush_word: got pv=%b pd=%h pc=%0d cnt=%0d buf=%h, want pv=1 pd=1b pc=3 cnt=0 buf=0",
               pkt_valid, pkt_data, pkt_count, dct_count, dct_buffer);
      fails++;
    end
    step();
  endtask

  task automatic test_backpressure();
    pkt_ready = 1'b0;
    send(2'b00, 31);
    tests++;
    if (pkt_valid !== 1'b1 || pkt_count !== 4'd15 || dct_count !== 4'd15 ||
        ovf !== 1'b1 || drop_count !== 8'd1) begin
      $display("FAIL backpressure: got pv=%b pc=%0d cnt=%0d ovf=%b drops=%0d, want pv=1 pc=15 cnt=15 ovf=1 drops=1",
               pkt_valid, pkt_count, dct_count, ovf, drop_count);
      fails++;
    end
    pkt_ready = 1'b1;
    step();
    tests++;
    if (pkt_valid !== 1'b1 || pkt_count !== 4'd15 || dct_count !== 4'd0) begin
      $display("FAIL backpressure_release: got pv=%b pc=%0d cnt=%0d, want pv=1 pc=15 cnt=0",
               pkt_valid, pkt_count, dct_count);
      fails++;
    end
    step();
    tests++;
    if (pkt_valid !== 1'b0) begin
      $display("FAIL backpressure_drain: got pv=%b, want 0", pkt_valid);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    pkt_ready = 1'b0;
    send(2'b11, 15);
    send(2'b10, 15);
    tests++;
    if (pkt_data !== 30'h3FFFFFFF || dct_count !== 4'd15 || drop_count !== 8'd1) begin
      $display("FAIL b2b_setup: got pd=%h cnt=%0d drops=%0d, want pd=3fffffff cnt=15 drops=1",
               pkt_data, dct_count, drop_count);
      fails++;
    end
    pkt_ready = 1'b1;
    send(2'b01, 1);
    tests++;
    if (pkt_valid !== 1'b1 || pkt_data !== 30'h2AAAAAAA || pkt_count !== 4'd15 ||
        dct_count !== 4'd1 || dct_buffer !== 30'h1 || drop_count !== 8'd1) begin
      $display("FAIL b2b_word: got pv=%b pd=%h pc=%0d cnt=%0d buf=%h drops=%0d, want pv=1 pd=2aaaaaaa pc=15 cnt=1 buf=1 drops=1",
               pkt_valid, pkt_data, pkt_count, dct_count, dct_buffer, drop_count);
      fails++;
    end
    step();
  endtask

  task automatic test_pending_flush();
    pkt_ready = 1'b0;
    send(2'b00, 14);
    tests++;
    if (pkt_valid !== 1'b1 || pkt_data !== 30'h10000000 || pkt_count !== 4'd15 || dct_count !== 4'd0) begin
      $display("FAIL pend_setup: got pv=%b pd=%h pc=%0d cnt=%0d, want pv=1 pd=10000000 pc=15 cnt=0",
               pkt_valid, pkt_data, pkt_count, dct_count);
      fails++;
    end
    flush = 1'b1; step(); flush = 1'b0;
    send(2'b11, 1); send(2'b10, 1);
    tests++;
    if (dct_count !== 4'd2 || dct_buffer !== 30'hE || pkt_data !== 30'h10000000 || pkt_count !== 4'd15) begin
      $display("FAIL pend_hold: got cnt=%0d buf=%h pd=%h pc=%0d, want cnt=2 buf=e pd=10000000 pc=15",
               dct_count, dct_buffer, pkt_data, pkt_count);
      fails++;
    end
    pkt_ready = 1'b1;
    step();
    tests++;
    if (pkt_valid !== 1'b1 || pkt_data !== 30'hE || pkt_count !== 4'd2 || dct_count !== 4'd0) begin
      $display("FAIL pend_emit: got pv=%b pd=%h pc=%0d cnt=%0d, want pv=1 pd=e pc=2 cnt=0",
               pkt_valid, pkt_data, pkt_count, dct_count);
      fails++;
    end
    step();
    flush = 1'b1; step(); flush = 1'b0;
    step();
    tests++;
    if (pkt_valid !== 1'b0 || dct_count !== 4'd0) begin
      $display("FAIL empty_flush: got pv=%b cnt=%0d, want pv=0 cnt=0", pkt_valid, dct_count);
      fails++;
    end
  endtask

  task automatic test_saturate_reset();
    pkt_ready = 1'b0;
    trace_valid = 1'b1; trace_code = 2'b10;
    for (int i = 0; i < 130; i++) step();
    tests++;
    if (drop_count !== 8'd101) begin
      $display("FAIL drop_mid: got drops=%0d, want 101", drop_count);
      fails++;
    end
    for (int i = 0; i < 200; i++) step();
    tests++;
    if (drop_count !== 8'd255 || ovf !== 1'b1) begin
      $display("FAIL drop_saturate: got drops=%0d ovf=%b, want drops=255 ovf=1", drop_count, ovf);
      fails++;
    end
    reset = 1'b1; step(); reset = 1'b0;
    trace_valid = 1'b0;
    tests++;
    if ({dct_buffer, dct_count, pkt_valid, pkt_data, pkt_count, ovf, drop_count} !== '0) begin
      $display("FAIL reset_mid: got buf=%h cnt=%0d pv=%b pd=%h pc=%0d ovf=%b drops=%0d, want all 0",
               dct_buffer, dct_count, pkt_valid, pkt_data, pkt_count, ovf, drop_count);
      fails++;
    end
    pkt_ready = 1'b1;
    step();
    tests++;
    if (pkt_valid !== 1'b0 || dct_count !== 4'd0) begin
      $display("FAIL reset_quiet: got pv=%b cnt=%0d, want pv=0 cnt=0", pkt_valid, dct_count);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_trace_en();
    test_full_word();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_pending_flush();
    test_saturate_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
